shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath: rotates or shifts a WIDTH-bit operand by a runtime amount in one of four modes. A log2(WIDTH)-level mux network sits behind a valid/ready handshake with full backpressure and a sideband tag. It replaces the fixed 8-bit combinational rotator wherever a registered, flow-controlled shifter is needed.

---
 rtl/shift_pipe_pkg.sv | 19 +
 rtl/shift_level.sv | 34 +++
 rtl/shift_pipe.sv | 121 ++++++++++++
 tb/tb_shift_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared types for the shift_pipe barrel shifter: shift mode encoding and the
// control portion of every stage register.
package shift_pipe_pkg;

    typedef enum logic [1:0] {
        SHIFT_SRL = 2'b00,
        SHIFT_SRA = 2'b01,
        SHIFT_ROR = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_e;

    // Width-independent part of a stage register; the owning module wraps it
    // with data/amt/tag fields sized from its own localparams.
    typedef struct packed {
        logic      vld;
        shift_op_e op;
    } stage_ctl_t;

endpackage

// File: rtl/shift_level.sv
// One level of the barrel-shifter network: optionally moves the operand by a
// fixed distance DIST in the requested mode.
module shift_level
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  shift_op_e        i_op,
    output logic [WIDTH-1:0] o_data
);

    logic signed [WIDTH-1:0] w_sdata;
    logic        [WIDTH-1:0] w_shift;

    // Earlier SRA levels keep the MSB intact, so the partial MSB is the sign.
    assign w_sdata = i_data;

    always_comb begin
        w_shift = i_data;
        case (i_op)
            SHIFT_SRL: w_shift = i_data >> DIST;
            SHIFT_SRA: w_shift = w_sdata >>> DIST;
            SHIFT_ROR: w_shift = (i_data >> DIST) | (i_data << (WIDTH - DIST));
            SHIFT_ROL: w_shift = (i_data << DIST) | (i_data >> (WIDTH - DIST));
            default:   w_shift = i_data;
        endcase
    end

    assign o_data = i_en ? w_shift : i_data;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready flow control and a sideband tag.
// Define SHIFT_PIPE_STAGE_REG_EN to register every network level.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic [TAG_W-1:0]   out_tag
);

    typedef struct packed {
        stage_ctl_t           ctl;
        logic [WIDTH-1:0]     data;
        logic [SHAMT_W-1:0]   amt;
        logic [TAG_W-1:0]     tag;
    } stage_t;

    stage_t w_in;
    stage_t w_final;
    logic   w_stall;
    logic   w_unused_final;

    always_comb begin
        w_in          = '0;
        w_in.ctl.vld  = in_valid;
        w_in.ctl.op   = shift_op_e'(in_op);
        w_in.data     = in_data;
        w_in.amt      = in_amt;
        w_in.tag      = in_tag;
    end

    // One global stall: the whole pipe freezes while the output beat waits.
    assign w_stall  = w_final.ctl.vld && !out_ready;
    assign in_ready = !w_stall;

    for (genvar j = 0; j < SHAMT_W; j++) begin : g_lvl
        localparam int K = SHAMT_W - 1 - j;

        stage_t           w_src;
        stage_t           w_next;
        logic [WIDTH-1:0] w_data;

        if (j == 0) begin : g_first
            assign w_src = w_in;
        end else begin : g_chain
`ifdef SHIFT_PIPE_STAGE_REG_EN
            assign w_src = g_lvl[j-1].r_stage;
`else
            assign w_src = g_lvl[j-1].w_next;
`endif
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << K)
        ) u_level (
            .i_data (w_src.data),
            .i_en   (w_src.amt[K]),
            .i_op   (w_src.ctl.op),
            .o_data (w_data)
        );

        // Consumed amount bits are cleared so each register holds only the remainder.
        always_comb begin
            w_next        = w_src;
            w_next.data   = w_data;
            w_next.amt[K] = 1'b0;
        end

`ifdef SHIFT_PIPE_STAGE_REG_EN
        stage_t r_stage;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_stage <= '0;
            end else if (!w_stall) begin
                r_stage <= w_next;
            end
        end
`endif
    end

`ifdef SHIFT_PIPE_STAGE_REG_EN
    assign w_final = g_lvl[SHAMT_W-1].r_stage;
`else
    stage_t r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (!w_stall) begin
            r_out <= g_lvl[SHAMT_W-1].w_next;
        end
    end

    assign w_final = r_out;
`endif

    assign out_valid = w_final.ctl.vld;
    assign out_data  = w_final.data;
    assign out_tag   = w_final.tag;
    assign out_zero  = (w_final.data == '0);

    // The remaining amount is always zero at the output and op is not exported.
    assign w_unused_final = ^{w_final.amt, w_final.ctl.op};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=8, TAG_W=4).
module tb_shift_pipe;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
`ifdef SHIFT_PIPE_STAGE_REG_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] in_data   = '0;
    logic [2:0]       in_amt    = '0;
    logic [1:0]       in_op     = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_zero;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    int   sent;
    int   recv;
    int   guard;
    logic acc;
    logic dlv;

    logic [7:0] bp_d [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] bp_e [4] = '{8'h21, 8'h43, 8'h65, 8'h87};

    always #5 clk = ~clk;

    shift_pipe #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] op, input logic [3:0] t);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = t;
    endtask

    task automatic run_beat(input string name, input logic [7:0] d, input logic [2:0] a,
                            input logic [1:0] op, input logic [3:0] t,
                            input logic [7:0] exp_d, input logic exp_z);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, d, a, op, t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"},  32'(lat),      32'(L));
        check({name, "_data"}, 32'(out_data), 32'(exp_d));
        check({name, "_tag"},  32'(out_tag),  32'(t));
        check({name, "_zero"}, 32'(out_zero), 32'(exp_z));
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_tag",   32'(out_tag),   32'd0);
        check("rst_zero",  32'(out_zero),  32'd1);
        check("rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_beat("ror_b4",   8'hB4, 3'd3, 2'b10, 4'd5,  8'h96, 1'b0);
        run_beat("srl_b4",   8'hB4, 3'd3, 2'b00, 4'd1,  8'h16, 1'b0);
        run_beat("sra_b4",   8'hB4, 3'd3, 2'b01, 4'd2,  8'hF6, 1'b0);
        run_beat("rol_b4",   8'hB4, 3'd3, 2'b11, 4'd3,  8'hA5, 1'b0);
        run_beat("sra_80_7", 8'h80, 3'd7, 2'b01, 4'd4,  8'hFF, 1'b0);
        run_beat("srl_amt0", 8'h5A, 3'd0, 2'b00, 4'd6,  8'h5A, 1'b0);
        run_beat("sra_amt0", 8'h5A, 3'd0, 2'b01, 4'd7,  8'h5A, 1'b0);
        run_beat("ror_amt0", 8'h5A, 3'd0, 2'b10, 4'd8,  8'h5A, 1'b0);
        run_beat("rol_amt0", 8'h5A, 3'd0, 2'b11, 4'd9,  8'h5A, 1'b0);
        run_beat("srl_01_1", 8'h01, 3'd1, 2'b00, 4'd10, 8'h00, 1'b1);
        run_beat("ror_81_1", 8'h81, 3'd1, 2'b10, 4'd11, 8'hC0, 1'b0);
        run_beat("rol_81_1", 8'h81, 3'd1, 2'b11, 4'd12, 8'h03, 1'b0);
        run_beat("sra_7f_7", 8'h7F, 3'd7, 2'b01, 4'd13, 8'h00, 1'b1);
        run_beat("srl_80_7", 8'h80, 3'd7, 2'b00, 4'd14, 8'h01, 1'b0);

        // Back-to-back stream: low nibble = tag, ROL 4 moves it to the high nibble.
        for (int c = 0; c < 16 + L; c++) begin
            @(negedge clk);
            if (c >= L) begin
                check("stream_vld",  32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data),  32'((c - L) << 4));
                check("stream_tag",  32'(out_tag),   32'(c - L));
            end
            if (c < 16) drive(1'b1, 8'(c), 3'd4, 2'b11, 4'(c));
            else        in_valid = 1'b0;
        end

        // Backpressure: hold out_ready low while offering beats.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 5 + L; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("bp_hold_data",  32'(out_data), 32'h21);
                check("bp_hold_tag",   32'(out_tag),  32'd8);
                check("bp_hold_ready", 32'(in_ready), 32'd0);
            end
            if (sent < 4) drive(1'b1, bp_d[sent], 3'd4, 2'b10, 4'(8 + sent));
            else          in_valid = 1'b0;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        #1;
        check("bp_full_vld", 32'(out_valid), 32'd1);
        check("bp_accepted", 32'(sent),      32'(L));

        out_ready = 1'b1;
        guard = 0;
        while (recv < 4 && guard < 30) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                check("bp_rel_data", 32'(out_data), 32'(bp_e[recv]));
                check("bp_rel_tag",  32'(out_tag),  32'(8 + recv));
            end
            dlv = out_valid && out_ready;
            if (sent < 4) drive(1'b1, bp_d[sent], 3'd4, 2'b10, 4'(8 + sent));
            else          in_valid = 1'b0;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (dlv) recv++;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_recv", 32'(recv), 32'd4);
        check("bp_sent", 32'(sent), 32'd4);

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < L + 1; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(8'hE0 + i), 3'd0, 2'b00, 4'(12 + i));
        end
        check("mid_pre_vld", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vld",   32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_tag",   32'(out_tag),   32'd0);
        check("mid_rst_zero",  32'(out_zero),  32'd1);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        run_beat("post_rst", 8'h3C, 3'd2, 2'b11, 4'd15, 8'hF0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
